// File: rtl/pid_pkg.sv
// ============================================================================
// Module      : pid_pkg
// Description : Shared widths, types and the saturation helper for the PID
//               P/I/D term generators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pid_pkg;

    localparam int c_ERR_W  = 10;
    localparam int c_DIFF_W = 7;
    localparam int c_COEF_W = 6;
    localparam int c_SAT_W  = 32;

    typedef logic signed [c_ERR_W-1:0] err_t;

    typedef struct packed {
        logic signed [c_SAT_W-1:0] val;
        logic                      hi;
        logic                      lo;
    } sat_res_t;

    // Clip a wide signed value into the out_w-bit signed range.
    function automatic sat_res_t sat_signed(input logic signed [c_SAT_W-1:0] in_v,
                                            input int                        out_w);
        logic signed [c_SAT_W-1:0] w_one;
        logic signed [c_SAT_W-1:0] w_max;
        logic signed [c_SAT_W-1:0] w_min;
        sat_res_t                  res;
        w_one   = 1;
        w_max   = (w_one <<< (out_w - 1)) - w_one;
        w_min   = ~w_max;
        res.val = in_v;
        res.hi  = 1'b0;
        res.lo  = 1'b0;
        if (in_v > w_max) begin
            res.val = w_max;
            res.hi  = 1'b1;
        end else if (in_v < w_min) begin
            res.val = w_min;
            res.lo  = 1'b1;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsat_stage.sv
// ============================================================================
// Module      : dsat_stage
// Description : Stage 1 of the derivative pipe: difference, saturation and
//               start-up priming mask, registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsat_stage
    import pid_pkg::*;
#(
    parameter int ERR_W  = c_ERR_W,
    parameter int DIFF_W = c_DIFF_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_vld,
    input  logic signed [ERR_W-1:0]  i_err,
    input  logic signed [ERR_W-1:0]  i_prev,
    input  logic                     i_primed,
    output logic signed [DIFF_W-1:0] o_diff,
    output logic                     o_hi,
    output logic                     o_lo,
    output logic                     o_vld
);

    logic signed [ERR_W:0]              w_diff;
    logic signed [c_SAT_W-1:0]          w_diff_ext;
    sat_res_t                           w_sat;
    logic [c_SAT_W-DIFF_W-1:0]          w_unused_sat_msbs;

    // One extra bit keeps the full-scale swing from wrapping.
    assign w_diff            = {i_err[ERR_W-1], i_err} - {i_prev[ERR_W-1], i_prev};
    assign w_diff_ext        = c_SAT_W'(w_diff);
    assign w_sat             = sat_signed(w_diff_ext, DIFF_W);
    assign w_unused_sat_msbs = w_sat.val[c_SAT_W-1:DIFF_W];

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            o_diff <= '0;
            o_hi   <= 1'b0;
            o_lo   <= 1'b0;
            o_vld  <= 1'b0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                if (i_primed) begin
                    o_diff <= w_sat.val[DIFF_W-1:0];
                    o_hi   <= w_sat.hi;
                    o_lo   <= w_sat.lo;
                end else begin
                    o_diff <= '0;
                    o_hi   <= 1'b0;
                    o_lo   <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/d_term_pipe.sv
// ============================================================================
// Module      : d_term_pipe
// Description : PID derivative term: history shift register, priming counter,
//               saturated difference stage and coefficient multiply stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_term_pipe
    import pid_pkg::*;
#(
    parameter int ERR_W  = c_ERR_W,
    parameter int DIFF_W = c_DIFF_W,
    parameter int COEF_W = c_COEF_W,
    parameter int DEPTH  = 2,
    localparam int OUT_W = DIFF_W + COEF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    err_vld,
    input  logic signed [ERR_W-1:0] err_sat,
    input  logic [COEF_W-1:0]       d_coeff,
    output logic signed [OUT_W-1:0] D_term,
    output logic                    D_vld,
    output logic                    sat_hi,
    output logic                    sat_lo,
    output logic                    primed
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic signed [ERR_W-1:0]  r_hist [DEPTH];
    logic [c_CNT_W-1:0]       r_prime_cnt;
    logic signed [DIFF_W-1:0] w_s1_diff;
    logic                     w_s1_hi;
    logic                     w_s1_lo;
    logic                     w_s1_vld;
    logic signed [OUT_W-1:0]  w_diff_ext;
    logic signed [OUT_W-1:0]  w_coef_ext;
    logic signed [OUT_W-1:0]  w_prod;

    assign primed = (r_prime_cnt == c_CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
            r_prime_cnt <= '0;
        end else if (err_vld) begin
            r_hist[0] <= err_sat;
            for (int i = 1; i < DEPTH; i++) r_hist[i] <= r_hist[i-1];
            if (!primed) r_prime_cnt <= r_prime_cnt + 1'b1;
        end
    end

    dsat_stage #(
        .ERR_W  (ERR_W),
        .DIFF_W (DIFF_W)
    ) u_dsat (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (clr),
        .i_vld    (err_vld),
        .i_err    (err_sat),
        .i_prev   (r_hist[DEPTH-1]),
        .i_primed (primed),
        .o_diff   (w_s1_diff),
        .o_hi     (w_s1_hi),
        .o_lo     (w_s1_lo),
        .o_vld    (w_s1_vld)
    );

    // Both operands widened to OUT_W: the product of a DIFF_W signed value and
    // a COEF_W unsigned gain always fits, so truncation loses nothing.
    assign w_diff_ext = {{COEF_W{w_s1_diff[DIFF_W-1]}}, w_s1_diff};
    assign w_coef_ext = $signed({{DIFF_W{1'b0}}, d_coeff});
    assign w_prod     = w_diff_ext * w_coef_ext;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            D_term <= '0;
            D_vld  <= 1'b0;
            sat_hi <= 1'b0;
            sat_lo <= 1'b0;
        end else begin
            D_vld <= w_s1_vld;
            if (w_s1_vld) begin
                D_term <= w_prod;
                sat_hi <= w_s1_hi;
                sat_lo <= w_s1_lo;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_d_term_pipe.sv
// ============================================================================
// Module      : tb_d_term_pipe
// Description : Scoreboard bench for d_term_pipe with a sample-queue reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_term_pipe;

    localparam int DEPTH  = 2;
    localparam int DIFF_W = 7;
    localparam int OUT_W  = 13;
    localparam int DMAX   = (1 << (DIFF_W - 1)) - 1;
    localparam int DMIN   = -(1 << (DIFF_W - 1));

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clr = 1'b0;
    logic                    err_vld = 1'b0;
    logic signed [9:0]       err_sat = '0;
    logic [5:0]              d_coeff = 6'd11;
    logic signed [OUT_W-1:0] D_term;
    logic                    D_vld;
    logic                    sat_hi;
    logic                    sat_lo;
    logic                    primed;

    d_term_pipe u_dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .err_vld (err_vld),
        .err_sat (err_sat),
        .d_coeff (d_coeff),
        .D_term  (D_term),
        .D_vld   (D_vld),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo),
        .primed  (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit hi;
        bit lo;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    bit   seen_rst = 0;
    bit   primed_exp = 0;
    int   held_d = 0;
    bit   held_hi = 0;
    bit   held_lo = 0;

    // Reference: keep the last DEPTH accepted samples, clip the difference,
    // and apply whatever gain is present one edge after acceptance.
    initial begin
        int  samples[$];
        bit  pend_v;
        int  pend_d;
        bit  pend_hi;
        bit  pend_lo;
        int  raw;
        pend_v = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst || clr) begin
                if (rst) seen_rst = 1;
                samples.delete();
                pend_v  = 0;
                held_d  = 0;
                held_hi = 0;
                held_lo = 0;
            end else begin
                if (pend_v) begin
                    exp_t it;
                    it.d   = pend_d * int'(d_coeff);
                    it.hi  = pend_hi;
                    it.lo  = pend_lo;
                    it.cyc = cyc;
                    exp_q.push_back(it);
                    held_d  = it.d;
                    held_hi = it.hi;
                    held_lo = it.lo;
                    pend_v  = 0;
                end
                if (err_vld) begin
                    pend_d  = 0;
                    pend_hi = 0;
                    pend_lo = 0;
                    if (samples.size() == DEPTH) begin
                        raw = int'(err_sat) - samples[0];
                        if (raw > DMAX) begin
                            pend_d  = DMAX;
                            pend_hi = 1;
                        end else if (raw < DMIN) begin
                            pend_d  = DMIN;
                            pend_lo = 1;
                        end else begin
                            pend_d = raw;
                        end
                    end
                    samples.push_back(int'(err_sat));
                    if (samples.size() > DEPTH) void'(samples.pop_front());
                    pend_v = 1;
                end
            end
            primed_exp = (samples.size() == DEPTH);
        end
    end

    // Directed point checks are handed to the monitor through these fields.
    int    spot_seq = 0;
    string s_name = "";
    bit    s_vld;
    int    s_d;
    bit    s_hi;
    bit    s_lo;
    bit    s_pr;
    bit    done = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, required %0d", nm, cyc, act, req);
        end
    endtask

    initial begin
        int spot_seen;
        spot_seen = 0;
        forever begin
            @(negedge clk);
            if (spot_seq != spot_seen) begin
                chk({s_name, ".vld"},    int'(D_vld),           int'(s_vld));
                chk({s_name, ".dterm"},  int'($signed(D_term)), s_d);
                chk({s_name, ".sat_hi"}, int'(sat_hi),          int'(s_hi));
                chk({s_name, ".sat_lo"}, int'(sat_lo),          int'(s_lo));
                chk({s_name, ".primed"}, int'(primed),          int'(s_pr));
                spot_seen = spot_seq;
            end
            if (seen_rst) begin
                if (D_vld) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_dvld", 1, 0);
                    end else begin
                        exp_t it;
                        it = exp_q.pop_front();
                        chk("sb.latency", cyc, it.cyc);
                        chk("sb.dterm",  int'($signed(D_term)), it.d);
                        chk("sb.sat_hi", int'(sat_hi), int'(it.hi));
                        chk("sb.sat_lo", int'(sat_lo), int'(it.lo));
                    end
                end else begin
                    chk("hold.dterm", int'($signed(D_term)), held_d);
                    chk("hold.flags", int'({sat_hi, sat_lo}), int'({held_hi, held_lo}));
                end
                chk("primed", int'(primed), int'(primed_exp));
            end
            if (done) begin
                chk("sb.drained", exp_q.size(), 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        err_vld = 1'b1;
        err_sat = 10'(v);
        tick();
        err_vld = 1'b0;
        tick();
    endtask

    task automatic spot(input string nm, input bit v, input int d,
                        input bit hi, input bit lo, input bit pr);
        s_name = nm;
        s_vld  = v;
        s_d    = d;
        s_hi   = hi;
        s_lo   = lo;
        s_pr   = pr;
        spot_seq++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        spot("reset", 0, 0, 0, 0, 0);

        send(100); spot("prime1", 1, 0, 0, 0, 0);
        send(120); spot("prime2", 1, 0, 0, 0, 1);
        send(130); spot("prime3", 1, 330, 0, 0, 1);

        clr = 1'b1; tick(); clr = 1'b0;
        send(0);    spot("sat.p0", 1, 0, 0, 0, 0);
        send(0);    spot("sat.p1", 1, 0, 0, 0, 1);
        send(200);  spot("sat.hi", 1, 693, 1, 0, 1);
        send(-300); spot("sat.lo", 1, -704, 0, 1, 1);

        clr = 1'b1; tick(); clr = 1'b0;
        send(-512); send(-512);
        send(511);  spot("nowrap", 1, 693, 1, 0, 1);

        clr = 1'b1; err_vld = 1'b1; err_sat = 10'sd5;
        tick();
        clr = 1'b0; err_vld = 1'b0;
        tick();
        spot("clr_drop", 0, 0, 0, 0, 0);
        send(7); spot("clr.p0", 1, 0, 0, 0, 0);
        send(9); spot("clr.p1", 1, 0, 0, 0, 1);

        err_vld = 1'b1; err_sat = 10'sd40;
        tick();
        err_vld = 1'b0; d_coeff = 6'd3;
        tick();
        spot("coef", 1, 99, 0, 0, 1);
        d_coeff = 6'd11;

        err_vld = 1'b1; err_sat = 10'sd50;
        tick();
        err_vld = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        spot("rst_kill", 0, 0, 0, 0, 0);
        tick();
        spot("rst_kill2", 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            err_vld = 1'b1;
            err_sat = 10'($urandom_range(0, 1023));
            tick();
        end
        err_vld = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            err_vld = 1'($urandom_range(0, 1));
            err_sat = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1) ? 511 : 512)
                                                  : 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) d_coeff = 6'($urandom_range(0, 63));
            tick();
        end
        rst = 1'b0; clr = 1'b0; err_vld = 1'b0;
        repeat (4) tick();
        done = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL timeout: monitor did not reach the summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
